// File: rtl/adc_arb_pkg.sv
// Shared state encoding, default widths and pointer-width helper for the ADC request arbiter.
package adc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam int unsigned NUM_REQ_DEF     = 4;
    localparam int unsigned CH_W_DEF        = 3;
    localparam int unsigned DATA_W_DEF      = 12;
    localparam int unsigned TIMEOUT_CYC_DEF = 1024;

    // Width of a requester index; never narrower than one bit.
    function automatic int unsigned ptr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_request_arbiter_if.sv
// Requester and ADC-controller signal bundle of the ADC request arbiter.
interface adc_request_arbiter_if
    import adc_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned CH_W    = CH_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF
) ();

    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*CH_W-1:0] req_ch;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ-1:0]      rsp_valid;
    logic [DATA_W-1:0]       rsp_data;
    logic                    rsp_err;
    logic                    adc_start;
    logic [CH_W-1:0]         adc_ch;
    logic                    adc_done;
    logic [DATA_W-1:0]       adc_data;
    logic                    busy;

    // Arbiter side.
    modport slave (
        input  req_valid, req_ch, adc_done, adc_data,
        output req_ready, rsp_valid, rsp_data, rsp_err, adc_start, adc_ch, busy
    );

    // Requesters plus ADC controller side.
    modport master (
        output req_valid, req_ch, adc_done, adc_data,
        input  req_ready, rsp_valid, rsp_data, rsp_err, adc_start, adc_ch, busy
    );

endinterface

// File: rtl/adc_request_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module rr_arbiter
    import adc_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned PTR_W   = ptr_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [PTR_W-1:0]   grant_idx_c
);

    // Walk from farthest to nearest so the nearest hit after last_grant wins.
    always_comb begin
        int unsigned      cand;
        logic [PTR_W-1:0] cand_idx;
        cand        = 0;
        cand_idx    = '0;
        grant_c     = '0;
        grant_idx_c = '0;
        for (int unsigned k = NUM_REQ; k > 0; k--) begin
            cand     = (32'(last_grant) + k) % NUM_REQ;
            cand_idx = PTR_W'(cand);
            if (req[cand_idx]) begin
                grant_c           = '0;
                grant_c[cand_idx] = 1'b1;
                grant_idx_c       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/adc_request_arbiter.sv
// Shares one serial-ADC controller among NUM_REQ requesters, one conversion at a time.
// Optional WAIT watchdog enabled by defining ADC_ARB_TIMEOUT_EN.
module adc_request_arbiter
    import adc_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = NUM_REQ_DEF,
    parameter int unsigned CH_W        = CH_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input logic                  clk_50,
    input logic                  reset_n,
    adc_request_arbiter_if.slave bus
);

    localparam int unsigned PTR_W = ptr_w(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("adc_request_arbiter: NUM_REQ must be in 2..8");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("adc_request_arbiter: TIMEOUT_CYC must be at least 2");
    end

    arb_state_e          state_q, state_d;
    logic [PTR_W-1:0]    last_grant_q, last_grant_d;
    logic [PTR_W-1:0]    gid_q, gid_d;
    logic [CH_W-1:0]     gch_q, gch_d;
    logic [NUM_REQ-1:0]  grant_c;
    logic [PTR_W-1:0]    grant_idx_c;
    logic [NUM_REQ-1:0]  req_ready_c;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic                adc_start_q, adc_start_d;
    logic                busy_q;
    logic                expire_c;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req         (bus.req_valid),
        .last_grant  (last_grant_q),
        .grant_c     (grant_c),
        .grant_idx_c (grant_idx_c)
    );

`ifdef ADC_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC);

    logic [TO_W-1:0] to_cnt_q;

    // Cleared while issuing so it reads zero on the first WAIT cycle.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_q <= '0;
        end else if (state_q == ISSUE) begin
            to_cnt_q <= '0;
        end else if (state_q == WAIT) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end

    assign expire_c = (state_q == WAIT) && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
`else
    assign expire_c = 1'b0;
`endif

    // Next state and next register values; adc_done wins over expiry.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gid_d        = gid_q;
        gch_d        = gch_q;
        req_ready_c  = '0;
        adc_start_d  = 1'b0;
        rsp_valid_d  = '0;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (reset_n && (|grant_c)) begin
                    req_ready_c = grant_c;
                    gid_d       = grant_idx_c;
                    gch_d       = bus.req_ch[32'(grant_idx_c) * CH_W +: CH_W];
                    adc_start_d = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.adc_done) begin
                    rsp_data_d  = bus.adc_data;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = NUM_REQ'(1) << gid_q;
                    state_d     = RESP;
                end else if (expire_c) begin
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = NUM_REQ'(1) << gid_q;
                    state_d     = RESP;
                end
            end
            RESP: begin
                last_grant_d = gid_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= PTR_W'(NUM_REQ - 1);
            gid_q        <= '0;
            gch_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            adc_start_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gid_q        <= gid_d;
            gch_q        <= gch_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            adc_start_q  <= adc_start_d;
            busy_q       <= (state_d != IDLE);
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.adc_start = adc_start_q;
    assign bus.adc_ch    = gch_q;
    assign bus.busy      = busy_q;

endmodule
